// File: rtl/bus_dma_pkg.sv
// Shared constants and types for the bus_dma copy engine.
// The optional fill mode is enabled by defining BUS_DMA_FILL_EN.
package bus_dma_pkg;

    localparam logic [3:0] REG_SRC  = 4'h0;
    localparam logic [3:0] REG_DST  = 4'h4;
    localparam logic [3:0] REG_LEN  = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;

    // CTRL write bits and STAT read bits share positions where they overlap
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_FILL     = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;

    typedef enum logic [1:0] {IDLE, RD, WR, STEP} dma_state_t;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_dma_regfile.sv
// Responder side of bus_dma: window decode, SRC/DST/LEN/CTRL registers,
// s_done/s_rdata generation and START/CLR_DONE pulses (FILL bit under BUS_DMA_FILL_EN).
module bus_dma_regfile
    import bus_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_wdata_i,
    input  logic [3:0]  s_wmask_i,
    input  logic        s_wen_i,
    input  logic        s_ren_i,
    output logic [31:0] s_rdata_o,
    output logic        s_done_o,
    output logic        s_active_o,
    input  logic        busy_i,
    input  logic        done_i,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [15:0] len_o,
    output logic        irq_en_o,
    output logic        fill_o,
    output logic        start_o,
    output logic        clr_done_o
);

    logic        served_q;
    logic        s_done_q;
    logic [31:0] s_rdata_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] len_q;
    logic        irq_en_q;
    logic        fill_q;
    logic        req;
    logic        take;
    logic        ctrl_wr;
    logic        cfg_wr;
    logic [3:0]  off;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        unused_addr;

    assign req         = s_wen_i | s_ren_i;
    assign s_active_o  = (s_addr_i[31:4] == BASE_ADDR[31:4]);
    // served_q blocks a held request from being taken twice
    assign take        = req & s_active_o & ~served_q;
    assign off         = {s_addr_i[3:2], 2'b00};
    assign unused_addr = ^s_addr_i[1:0];
    assign ctrl_wr     = take & s_wen_i & (off == REG_CTRL) & s_wmask_i[0];
    assign cfg_wr      = take & s_wen_i & ~busy_i;
    assign start_o     = ctrl_wr & s_wdata_i[CTRL_START] & ~busy_i;
    assign clr_done_o  = ctrl_wr & s_wdata_i[CTRL_CLR_DONE];

    always_comb begin
        rd_val = '0;
        wr_val = '0;
        case (off)
            REG_SRC: begin
                rd_val = src_q;
                wr_val = apply_wmask(src_q, s_wdata_i, s_wmask_i);
            end
            REG_DST: begin
                rd_val = dst_q;
                wr_val = apply_wmask(dst_q, s_wdata_i, s_wmask_i);
            end
            REG_LEN: begin
                rd_val = {16'h0, len_q};
                wr_val = apply_wmask({16'h0, len_q}, s_wdata_i, s_wmask_i);
            end
            default: begin
                rd_val[STAT_BUSY]   = busy_i;
                rd_val[STAT_DONE]   = done_i;
                rd_val[CTRL_FILL]   = fill_q;
                rd_val[CTRL_IRQ_EN] = irq_en_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_q  <= 1'b0;
            s_done_q  <= 1'b0;
            s_rdata_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            irq_en_q  <= 1'b0;
        end else begin
            s_done_q  <= take;
            s_rdata_q <= (take & s_ren_i) ? rd_val : '0;
            served_q  <= take | (served_q & req);
            if (cfg_wr) begin
                case (off)
                    REG_SRC: src_q <= {wr_val[31:2], 2'b00};
                    REG_DST: dst_q <= {wr_val[31:2], 2'b00};
                    REG_LEN: len_q <= wr_val[15:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) irq_en_q <= s_wdata_i[CTRL_IRQ_EN];
        end
    end

`ifdef BUS_DMA_FILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          fill_q <= 1'b0;
        else if (ctrl_wr) fill_q <= s_wdata_i[CTRL_FILL];
    end
`else
    assign fill_q = 1'b0;
`endif

    assign s_done_o  = s_done_q;
    assign s_rdata_o = s_rdata_q;
    assign src_o     = src_q;
    assign dst_o     = dst_q;
    assign len_o     = len_q;
    assign irq_en_o  = irq_en_q;
    assign fill_o    = fill_q;

endmodule

// File: rtl/bus_dma.sv
// Memory-to-memory word copy engine: register responder plus bus initiator FSM.
// Define BUS_DMA_FILL_EN to enable pattern-fill mode (CTRL bit2).
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wmask,
    input  logic        s_wen,
    input  logic        s_ren,
    output logic [31:0] s_rdata,
    output logic        s_done,
    output logic        s_active,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    input  logic        m_done,
    output logic        irq
);

    dma_state_t  state_q;
    logic [31:0] cur_src_q;
    logic [31:0] cur_dst_q;
    logic [15:0] cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        fill_run_q;
    logic        m_ren_q;
    logic        m_wen_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;

    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        irq_en;
    logic        fill;
    logic        start;
    logic        clr_done;

    bus_dma_regfile #(.BASE_ADDR(BASE_ADDR)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .s_addr_i   (s_addr),
        .s_wdata_i  (s_wdata),
        .s_wmask_i  (s_wmask),
        .s_wen_i    (s_wen),
        .s_ren_i    (s_ren),
        .s_rdata_o  (s_rdata),
        .s_done_o   (s_done),
        .s_active_o (s_active),
        .busy_i     (busy_q),
        .done_i     (done_q),
        .src_o      (src),
        .dst_o      (dst),
        .len_o      (len),
        .irq_en_o   (irq_en),
        .fill_o     (fill),
        .start_o    (start),
        .clr_done_o (clr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_src_q  <= '0;
            cur_dst_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fill_run_q <= 1'b0;
            m_ren_q    <= 1'b0;
            m_wen_q    <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            if (clr_done) done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            cur_src_q  <= src;
                            cur_dst_q  <= dst;
                            cnt_q      <= len;
                            fill_run_q <= fill;
                            if (fill) begin
                                state_q   <= WR;
                                m_wen_q   <= 1'b1;
                                m_addr_q  <= dst;
                                m_wdata_q <= src;
                            end else begin
                                state_q  <= RD;
                                m_ren_q  <= 1'b1;
                                m_addr_q <= src;
                            end
                        end
                    end
                end
                RD: begin
                    if (m_done) begin
                        // m_wdata_q doubles as the latched read word
                        state_q   <= WR;
                        m_ren_q   <= 1'b0;
                        m_wen_q   <= 1'b1;
                        m_addr_q  <= cur_dst_q;
                        m_wdata_q <= m_rdata;
                    end
                end
                WR: begin
                    if (m_done) begin
                        state_q <= STEP;
                        m_wen_q <= 1'b0;
                    end
                end
                STEP: begin
                    cur_src_q <= cur_src_q + 32'd4;
                    cur_dst_q <= cur_dst_q + 32'd4;
                    cnt_q     <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (fill_run_q) begin
                        state_q  <= WR;
                        m_wen_q  <= 1'b1;
                        m_addr_q <= cur_dst_q + 32'd4;
                    end else begin
                        state_q  <= RD;
                        m_ren_q  <= 1'b1;
                        m_addr_q <= cur_src_q + 32'd4;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wmask = 4'hF;
    assign m_wen   = m_wen_q;
    assign m_ren   = m_ren_q;
    assign irq     = done_q & irq_en;

endmodule

// File: tb/tb_bus_dma.sv
// Directed testbench for bus_dma: register programming through the responder
// port, a waited memory model on the initiator port, and a scoreboard of bus/register results.
module tb_bus_dma;

    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int          RD_WAIT = 1;
    localparam int          WR_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wmask = '0;
    logic        s_wen = 1'b0;
    logic        s_ren = 1'b0;
    logic [31:0] s_rdata;
    logic        s_done;
    logic        s_active;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_wen;
    logic        m_ren;
    logic [31:0] m_rdata = '0;
    logic        m_done = 1'b0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [logic [31:0]];
    // expected initiator transactions: {is_write, addr, data}
    logic [64:0] exp_bus_q[$];
    logic [31:0] exp_rd_q[$];
    string       exp_nm_q[$];
    logic        chk_rd = 1'b0;

    bus_dma #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_wen(s_wen), .s_ren(s_ren), .s_rdata(s_rdata),
        .s_done(s_done), .s_active(s_active),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_wen(m_wen), .m_ren(m_ren), .m_rdata(m_rdata),
        .m_done(m_done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // initiator-side memory model with fixed wait states
    initial begin : mem_model
        int wcnt;
        logic [64:0] txn;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst || m_done) begin
                m_done = 1'b0;
                wcnt = 0;
            end else if (m_ren || m_wen) begin
                check("ren_wen_exclusive", {64'h0, m_ren & m_wen}, 65'h0);
                if (wcnt >= (m_ren ? RD_WAIT : WR_WAIT)) begin
                    m_done = 1'b1;
                    wcnt = 0;
                    if (m_ren) begin
                        m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
                        txn = {1'b0, m_addr, m_rdata};
                    end else begin
                        mem[m_addr] = m_wdata;
                        txn = {1'b1, m_addr, m_wdata};
                        check("m_wmask", {61'h0, m_wmask}, 65'hF);
                    end
                    if (exp_bus_q.size() == 0) check("bus_unexpected", txn, 65'h0);
                    else check("bus_txn", txn, exp_bus_q.pop_front());
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // responder read monitor
    always @(negedge clk) begin
        if (s_done && s_ren && chk_rd) begin
            if (exp_rd_q.size() == 0) check("rd_unexpected", {33'h0, s_rdata}, 65'h0);
            else check(exp_nm_q.pop_front(), {33'h0, s_rdata}, {33'h0, exp_rd_q.pop_front()});
        end
    end

    task automatic reg_access(input logic wr, input logic [3:0] off, input logic [31:0] d,
                              input logic [3:0] mask, output logic [31:0] q);
        int t;
        @(posedge clk); #1;
        s_addr = BASE + {28'h0, off};
        s_wdata = d;
        s_wmask = mask;
        s_wen = wr;
        s_ren = ~wr;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!s_done && t < 50);
        q = s_rdata;
        if (!s_done) check("s_done_timeout", 65'h0, 65'h1);
        @(posedge clk); #1;
        s_wen = 1'b0;
        s_ren = 1'b0;
    endtask

    task automatic reg_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] mask = 4'hF);
        logic [31:0] q;
        reg_access(1'b1, off, d, mask, q);
    endtask

    task automatic rd_chk(input logic [3:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] q;
        exp_rd_q.push_back(exp);
        exp_nm_q.push_back(nm);
        chk_rd = 1'b1;
        reg_access(1'b0, off, 32'h0, 4'hF, q);
        chk_rd = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] q;
        int n;
        n = 0;
        do begin
            reg_access(1'b0, 4'hC, 32'h0, 4'hF, q);
            n++;
        end while (q[0] && n < 100);
        if (q[0]) check("busy_timeout", 65'h1, 65'h0);
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            exp_bus_q.push_back({1'b0, src + 32'(4*i), mem[src + 32'(4*i)]});
            exp_bus_q.push_back({1'b1, dst + 32'(4*i), mem[src + 32'(4*i)]});
        end
    endtask

    initial begin : main
        int t;
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_m_ren", {64'h0, m_ren}, 65'h0);
        check("rst_m_wen", {64'h0, m_wen}, 65'h0);
        check("rst_irq", {64'h0, irq}, 65'h0);
        check("rst_s_done", {64'h0, s_done}, 65'h0);
        rd_chk(4'h0, 32'h0, "rst_src");
        rd_chk(4'h4, 32'h0, "rst_dst");
        rd_chk(4'h8, 32'h0, "rst_len");
        rd_chk(4'hC, 32'h0, "rst_ctrl");

        // basic four-word copy
        reg_wr(4'h0, 32'h100);
        reg_wr(4'h4, 32'h200);
        reg_wr(4'h8, 32'h4);
        push_copy(32'h100, 32'h200, 4);
        reg_wr(4'hC, 32'h1);
        wait_idle();
        rd_chk(4'hC, 32'h2, "copy_stat");
        for (int i = 0; i < 4; i++)
            check("copy_mem", {33'h0, mem[32'h200 + 32'(4*i)]}, {33'h0, 32'hA0 + 32'(i)});
        rd_chk(4'h0, 32'h100, "copy_src_kept");
        rd_chk(4'h8, 32'h4, "copy_len_kept");

        // byte masks, forced alignment, 16-bit LEN
        reg_wr(4'h0, 32'h1234_5677, 4'b0011);
        rd_chk(4'h0, 32'h0000_5674, "src_masked");
        reg_wr(4'h8, 32'hABCD_1234);
        rd_chk(4'h8, 32'h0000_1234, "len_16bit");

        // LEN=0 start: no traffic, DONE only
        reg_wr(4'hC, 32'h2);
        rd_chk(4'hC, 32'h0, "clr_done_stat");
        reg_wr(4'h8, 32'h0);
        reg_wr(4'hC, 32'h1);
        rd_chk(4'hC, 32'h2, "len0_stat");

        // writes and START while busy are ignored
        reg_wr(4'h0, 32'h100);
        reg_wr(4'h4, 32'h400);
        reg_wr(4'h8, 32'h4);
        push_copy(32'h100, 32'h400, 4);
        reg_wr(4'hC, 32'h1);
        reg_wr(4'h4, 32'h900);
        rd_chk(4'h4, 32'h400, "busy_dst_kept");
        reg_wr(4'hC, 32'h1);
        wait_idle();
        rd_chk(4'h4, 32'h400, "busy_dst_after");
        check("busy_mem_last", {33'h0, mem[32'h40C]}, {33'h0, 32'hA3});
        check("busy_no_900", {64'h0, mem.exists(32'h900)}, 65'h0);

        // reset during the write of the second word
        reg_wr(4'h4, 32'h500);
        exp_bus_q.push_back({1'b0, 32'h100, 32'hA0});
        exp_bus_q.push_back({1'b1, 32'h500, 32'hA0});
        exp_bus_q.push_back({1'b0, 32'h104, 32'hA1});
        reg_wr(4'hC, 32'h1);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(m_wen && m_addr == 32'h504) && t < 200);
        check("mid_wr_seen", {64'h0, m_wen}, 65'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_m_wen", {64'h0, m_wen}, 65'h0);
        check("mid_rst_irq", {64'h0, irq}, 65'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_chk(4'h0, 32'h0, "mid_rst_src");
        rd_chk(4'h4, 32'h0, "mid_rst_dst");
        rd_chk(4'h8, 32'h0, "mid_rst_len");
        rd_chk(4'hC, 32'h0, "mid_rst_ctrl");
        check("abandoned_wr", {64'h0, mem.exists(32'h504)}, 65'h0);
        reg_wr(4'h0, 32'h100);
        reg_wr(4'h4, 32'h600);
        reg_wr(4'h8, 32'h2);
        push_copy(32'h100, 32'h600, 2);
        reg_wr(4'hC, 32'h1);
        wait_idle();
        check("fresh_mem1", {33'h0, mem[32'h604]}, {33'h0, 32'hA1});

        // interrupt
        reg_wr(4'h0, 32'h10C);
        reg_wr(4'h4, 32'h700);
        reg_wr(4'h8, 32'h1);
        push_copy(32'h10C, 32'h700, 1);
        reg_wr(4'hC, 32'h9);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!irq && t < 200);
        check("irq_rise", {64'h0, irq}, 65'h1);
        rd_chk(4'hC, 32'hA, "irq_stat");
        reg_wr(4'hC, 32'hA);
        check("irq_clr", {64'h0, irq}, 65'h0);
        rd_chk(4'hC, 32'h8, "irq_clr_stat");

        // START together with CLR_DONE: START wins, DONE ends clear
        reg_wr(4'h8, 32'h0);
        reg_wr(4'hC, 32'h1);
        reg_wr(4'h0, 32'h100);
        reg_wr(4'h4, 32'h800);
        reg_wr(4'h8, 32'h4);
        push_copy(32'h100, 32'h800, 4);
        reg_wr(4'hC, 32'h3);
        rd_chk(4'hC, 32'h1, "start_clr_stat");
        wait_idle();
        rd_chk(4'hC, 32'h2, "start_clr_end");

        // FILL bit: stored only when the fill feature is built in
        reg_wr(4'hC, 32'h6);
`ifdef BUS_DMA_FILL_EN
        rd_chk(4'hC, 32'h4, "fill_bit");
        reg_wr(4'h0, 32'hDEAD_BEEF);
        reg_wr(4'h4, 32'h300);
        reg_wr(4'h8, 32'h3);
        // SRC low bits are forced to zero, so the pattern is ...EC
        for (int i = 0; i < 3; i++)
            exp_bus_q.push_back({1'b1, 32'h300 + 32'(4*i), 32'hDEAD_BEEC});
        reg_wr(4'hC, 32'h5);
        wait_idle();
        rd_chk(4'hC, 32'h6, "fill_stat");
        check("fill_mem", {33'h0, mem[32'h308]}, {33'h0, 32'hDEAD_BEEC});
`else
        rd_chk(4'hC, 32'h0, "fill_bit_absent");
`endif

        repeat (10) @(posedge clk);
        check("bus_q_empty", 65'(exp_bus_q.size()), 65'h0);
        check("rd_q_empty", 65'(exp_rd_q.size()), 65'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
